soi_access_ctrl: RTL and testbench

Arbitrating controller that shares one observed signal-of-interest (SOI) register between several access requesters, such as DPI-driven host probes and on-chip debug agents. It grants one requester at a time round-robin and freezes the SOI register's free-running update for a coherent read or write. It then drives the write override or captures the read value, and returns a response over a per-requester valid/ready handshake. It sits between the requesters and the SOI register's owning module, which exposes `soi_q` and accepts `run_en`, `soi_we` and `soi_wdata`.

---
 rtl/soi_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_soi_access_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soi_access_ctrl.sv
// soi_access_ctrl: round-robin arbiter that grants one requester at a time
// coherent access to a shared signal-of-interest register. The register's
// free-running update is frozen around the access, a write override or read
// capture is performed, and the result is returned on a per-requester
// valid/ready response channel.
module soi_access_ctrl #(
   parameter int  N_REQ  = 4,
   parameter int  DATA_W = 8,
   localparam int ID_W   = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_write,
   input  logic [N_REQ*DATA_W-1:0] req_wdata,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        rsp_valid,
   input  logic [N_REQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]       rsp_data,
   input  logic [DATA_W-1:0]       soi_q,
   output logic                    run_en,
   output logic                    soi_we,
   output logic [DATA_W-1:0]       soi_wdata,
   output logic                    busy,
   output logic [ID_W-1:0]         grant_id
);

   typedef enum logic [1:0] {
      IDLE,
      FREEZE,
      ACCESS,
      RESP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   sel;
   logic              sel_found;
   logic              accept;
   logic              rsp_done;
   logic              wr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [DATA_W-1:0] soi_wdata_q;

   // Round-robin pick: first requesting index after last_grant, wrapping at N_REQ-1
   always_comb begin
      logic [ID_W-1:0] cand;
      cand      = last_grant;
      sel       = last_grant;
      sel_found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (cand == ID_W'(N_REQ - 1)) begin
            cand = '0;
         end else begin
            cand = cand + ID_W'(1);
         end
         if (!sel_found && req_valid[cand]) begin
            sel       = cand;
            sel_found = 1'b1;
         end
      end
   end

   assign accept   = (state == IDLE) && sel_found;
   assign rsp_done = (state == RESP) && rsp_ready[grant_id];

   // State register; reset drops straight back to IDLE, aborting any access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: accept -> freeze -> access -> respond until the requester takes it
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = FREEZE;
         FREEZE:  state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    if (rsp_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant bookkeeping, latched request payload, captured response and last written value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant  <= ID_W'(N_REQ - 1);
         grant_id    <= '0;
         wr_q        <= 1'b0;
         wdata_q     <= '0;
         rsp_data_q  <= '0;
         soi_wdata_q <= '0;
      end else begin
         if (accept) begin
            grant_id <= sel;
            wr_q     <= req_write[sel];
            wdata_q  <= req_wdata[sel*DATA_W +: DATA_W];
         end
         if (state == ACCESS) begin
            rsp_data_q <= wr_q ? wdata_q : soi_q;
            if (wr_q) begin
               soi_wdata_q <= wdata_q;
            end
         end
         if (rsp_done) begin
            last_grant <= grant_id;
         end
      end
   end

   // Per-state outputs; SOI register free-runs only in IDLE and RESP
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      run_en    = 1'b1;
      soi_we    = 1'b0;
      unique case (state)
         IDLE: begin
            if (sel_found) begin
               req_ready[sel] = 1'b1;
            end
         end
         FREEZE: begin
            run_en = 1'b0;
         end
         ACCESS: begin
            run_en = 1'b0;
            soi_we = wr_q;
         end
         RESP: begin
            rsp_valid[grant_id] = 1'b1;
         end
         default: begin
            run_en = 1'b1;
         end
      endcase
   end

   assign busy      = (state != IDLE);
   assign rsp_data  = rsp_data_q;
   assign soi_wdata = soi_we ? wdata_q : soi_wdata_q;

endmodule

// File: tb/tb_soi_access_ctrl.sv
// tb_soi_access_ctrl: directed bench for soi_access_ctrl with a small SOI
// register model, a response scoreboard queue and a negedge monitor.
module tb_soi_access_ctrl;

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_write;
   logic [31:0] req_wdata;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [3:0]  rsp_ready;
   logic [7:0]  rsp_data;
   logic [7:0]  soi;
   logic        run_en;
   logic        soi_we;
   logic [7:0]  soi_wdata;
   logic        busy;
   logic [1:0]  grant_id;

   int          total;
   int          bad;
   int          cyc;
   int          weCount;
   int          lastAcceptCyc;
   bit          freeRun;
   logic [7:0]  lastWritten;
   logic [7:0]  lastExp;
   exp_t        expQ[$];

   soi_access_ctrl #(
      .N_REQ  (4),
      .DATA_W (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .soi_q     (soi),
      .run_en    (run_en),
      .soi_we    (soi_we),
      .soi_wdata (soi_wdata),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to measure grant spacing
   initial cyc = 0;
   always @(posedge clk) cyc++;

   // Counts write strobes seen by the SOI register
   initial weCount = 0;
   always @(negedge clk) if (soi_we) weCount++;

   // SOI register owned by the surrounding design: counts up while enabled, takes overrides
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         soi <= 8'h01;
      end else if (soi_we) begin
         soi <= soi_wdata;
      end else if (run_en && freeRun) begin
         soi <= soi + 8'h01;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
      end
   endtask

   // Response monitor: every accepted response must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && ((rsp_valid & rsp_ready) != 4'b0000)) begin
         if (expQ.size() == 0) begin
            checkOutput("rsp_unexpected", {28'b0, rsp_valid}, 32'h0);
         end else begin
            e = expQ.pop_front();
            checkOutput("rsp_valid_id", {28'b0, rsp_valid}, 32'd1 << e.id);
            checkOutput("rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
         end
      end
   end

   // Issue one request and follow it through FREEZE (and ACCESS/RESP when fullPhases)
   task automatic applyStimulus(input int id, input bit wr, input logic [7:0] wd,
                                input int expOverride, input bit fullPhases);
      int         waited;
      logic [7:0] expData;
      exp_t       e;
      waited = 0;
      req_write[id]        = wr;
      req_wdata[id*8 +: 8] = wd;
      req_valid[id]        = 1'b1;
      #1;
      while (req_ready[id] !== 1'b1 && waited < 40) begin
         @(posedge clk); #2;
         waited++;
      end
      if (req_ready[id] !== 1'b1) begin
         checkOutput("accept_timeout", 32'h0, 32'h1);
         req_valid[id] = 1'b0;
         return;
      end
      checkOutput("req_ready", {28'b0, req_ready}, 32'd1 << id);
      lastAcceptCyc = cyc;
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      if (expOverride >= 0) begin
         expData = expOverride[7:0];
      end else begin
         expData = wr ? wd : soi;
      end
      lastExp = expData;
      if (fullPhases) begin
         e.id   = id;
         e.data = expData;
         expQ.push_back(e);
      end
      checkOutput("freeze_run_en", {31'b0, run_en}, 32'h0);
      checkOutput("freeze_busy", {31'b0, busy}, 32'h1);
      checkOutput("freeze_grant_id", {30'b0, grant_id}, id);
      checkOutput("freeze_soi_we", {31'b0, soi_we}, 32'h0);
      checkOutput("freeze_soi_wdata", {24'b0, soi_wdata}, {24'b0, lastWritten});
      if (!fullPhases) return;
      @(posedge clk); #1;
      checkOutput("access_run_en", {31'b0, run_en}, 32'h0);
      checkOutput("access_soi_we", {31'b0, soi_we}, {31'b0, wr});
      checkOutput("access_rsp_valid", {28'b0, rsp_valid}, 32'h0);
      if (wr) begin
         checkOutput("access_soi_wdata", {24'b0, soi_wdata}, {24'b0, wd});
         lastWritten = wd;
      end
      @(posedge clk); #1;
      checkOutput("resp_run_en", {31'b0, run_en}, 32'h1);
      checkOutput("resp_soi_we", {31'b0, soi_we}, 32'h0);
      checkOutput("resp_soi_wdata", {24'b0, soi_wdata}, {24'b0, lastWritten});
      checkOutput("resp_rsp_valid", {28'b0, rsp_valid}, 32'd1 << id);
   endtask

   // Hard stop if the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      int   waited;
      int   prevCyc;
      int   weBefore;
      exp_t e;
      total       = 0;
      bad         = 0;
      waited      = 0;
      prevCyc     = 0;
      weBefore    = 0;
      freeRun     = 1'b1;
      lastWritten = 8'h00;
      lastExp     = 8'h00;
      rst_n       = 1'b0;
      req_valid   = '0;
      req_write   = '0;
      req_wdata   = '0;
      rsp_ready   = '1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_req_ready", {28'b0, req_ready}, 32'h0);
      checkOutput("rst_rsp_valid", {28'b0, rsp_valid}, 32'h0);
      checkOutput("rst_rsp_data", {24'b0, rsp_data}, 32'h0);
      checkOutput("rst_soi_we", {31'b0, soi_we}, 32'h0);
      checkOutput("rst_soi_wdata", {24'b0, soi_wdata}, 32'h0);
      checkOutput("rst_run_en", {31'b0, run_en}, 32'h1);
      checkOutput("rst_busy", {31'b0, busy}, 32'h0);
      checkOutput("rst_grant_id", {30'b0, grant_id}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single read by requester 0 with the SOI counting
      applyStimulus(0, 1'b0, 8'h00, -1, 1'b1);
      @(posedge clk); #1;

      // Single write of 0xA5 by requester 2, then read-back by requester 1 with SOI held
      freeRun = 1'b0;
      applyStimulus(2, 1'b1, 8'hA5, -1, 1'b1);
      @(posedge clk); #1;
      applyStimulus(1, 1'b0, 8'h00, 32'hA5, 1'b1);
      @(posedge clk); #1;
      freeRun = 1'b1;

      // Response back-pressure on requester 3 while requester 1 waits
      rsp_ready[3] = 1'b0;
      applyStimulus(3, 1'b0, 8'h00, -1, 1'b1);
      req_write[1] = 1'b0;
      req_valid[1] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checkOutput("bp_rsp_valid", {28'b0, rsp_valid}, 32'h8);
         checkOutput("bp_rsp_data", {24'b0, rsp_data}, {24'b0, lastExp});
         checkOutput("bp_req_ready", {28'b0, req_ready}, 32'h0);
         @(posedge clk); #1;
      end
      rsp_ready[3] = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_req1_ready", {28'b0, req_ready}, 32'h2);
      applyStimulus(1, 1'b0, 8'h00, -1, 1'b1);
      @(posedge clk); #1;

      // Round-robin with all four requesters reading continuously, after a fresh reset
      rst_n       = 1'b0;
      lastWritten = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      req_write = '0;
      req_valid = '1;
      for (int k = 0; k < 5; k++) begin
         waited = 0;
         #1;
         while (req_ready == 4'b0000 && waited < 20) begin
            @(posedge clk); #2;
            waited++;
         end
         checkOutput("rr_grant", {28'b0, req_ready}, 32'd1 << (k % 4));
         if (k > 0) begin
            checkOutput("rr_spacing", cyc - prevCyc, 32'd4);
         end
         prevCyc = cyc;
         @(posedge clk); #1;
         e.id   = k % 4;
         e.data = soi;
         expQ.push_back(e);
         if (k == 4) begin
            req_valid = '0;
         end
      end
      repeat (4) @(posedge clk);
      #1;

      // Reset during FREEZE of a 0x3C write aborts it without a strobe
      applyStimulus(2, 1'b1, 8'h3C, -1, 1'b0);
      weBefore = weCount;
      rst_n    = 1'b0;
      #1;
      checkOutput("abort_run_en", {31'b0, run_en}, 32'h1);
      checkOutput("abort_busy", {31'b0, busy}, 32'h0);
      checkOutput("abort_soi_we", {31'b0, soi_we}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("abort_rsp_valid", {28'b0, rsp_valid}, 32'h0);
      lastWritten = 8'h00;
      rst_n       = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort_no_we", weCount - weBefore, 32'h0);
      req_write[3] = 1'b0;
      req_valid[3] = 1'b1;
      applyStimulus(0, 1'b0, 8'h00, -1, 1'b1);
      req_valid[3] = 1'b0;
      @(posedge clk); #1;

      // Early withdraw: requester 1 asks while busy and leaves before IDLE
      rsp_ready[0] = 1'b0;
      applyStimulus(0, 1'b0, 8'h00, -1, 1'b1);
      req_write[1] = 1'b0;
      req_valid[1] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         checkOutput("ew_busy_req_ready", {28'b0, req_ready}, 32'h0);
         @(posedge clk); #1;
      end
      req_valid[1] = 1'b0;
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("ew_idle_busy", {31'b0, busy}, 32'h0);
         checkOutput("ew_idle_req_ready", {28'b0, req_ready}, 32'h0);
         checkOutput("ew_grant_id", {30'b0, grant_id}, 32'h0);
         @(posedge clk); #1;
      end

      checkOutput("queue_drained", expQ.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
